// File: rtl/cmp_pkg.sv
// Shared types for the comparator scheduler: FSM state encoding and the
// registered comparison result.
package cmp_pkg;

   // Widest requester index supported (N_REQ up to 8).
   localparam int ID_W_MAX = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RSP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ID_W_MAX-1:0] id;
      logic                greater;
      logic                equal;
      logic                less;
   } cmp_res_t;

endpackage

// File: rtl/cmp_sched_comparator.sv
// Combinational unsigned magnitude comparator shared by all requesters;
// exactly one of the three outputs is high for any operand pair.
module cmp_sched_comparator #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              a_greater,
   output logic              a_equal,
   output logic              a_less
);

   assign a_greater = (a > b);
   assign a_equal   = (a == b);
   assign a_less    = (a < b);

endmodule

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one comparator among N_REQ requesters.
// Optional response counter enabled with CMP_SCHED_STATS_EN.
module cmp_sched
   import cmp_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_a,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_b,
   output logic [N_REQ-1:0]               req_ready,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [$clog2(N_REQ)-1:0]       rsp_id,
   output logic                           rsp_greater,
   output logic                           rsp_equal,
   output logic                           rsp_less,
   output logic                           busy
`ifdef CMP_SCHED_STATS_EN
   ,
   output logic [15:0]                    stat_count
`endif
);

   localparam int             IDX_W    = $clog2(N_REQ);
   localparam logic [IDX_W:0] N_REQ_W  = (IDX_W+1)'(N_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ-1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IDX_W-1:0]  rr_ptr_r;
   logic [IDX_W-1:0]  ptr_nxt_s;
   logic [IDX_W-1:0]  id_r;
   logic [IDX_W-1:0]  grant_idx_s;
   logic              grant_found_s;
   logic [IDX_W:0]    cand_s;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic              gt_s;
   logic              eq_s;
   logic              lt_s;
   cmp_res_t          res_r;
   logic              unused_id_s;

   cmp_sched_comparator #(
      .DATA_W (DATA_W)
   ) u_cmp (
      .a         (a_r),
      .b         (b_r),
      .a_greater (gt_s),
      .a_equal   (eq_s),
      .a_less    (lt_s)
   );

   // Round-robin search: first valid requester at or after rr_ptr, modulo N_REQ.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_s        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
         if (cand_s >= N_REQ_W) begin
            cand_s = cand_s - N_REQ_W;
         end else begin
            cand_s = cand_s;
         end
         if (!grant_found_s && req_valid[cand_s[IDX_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s[IDX_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
            grant_idx_s   = grant_idx_s;
         end
      end
   end

   assign ptr_nxt_s = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + IDX_W'(1));

   // Next-state logic; the grant strobe is only ever raised in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = '0;
      case (state_r)
         IDLE: begin
            if (grant_found_s) begin
               state_nxt_s            = CMP;
               req_ready[grant_idx_s] = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CMP: begin
            state_nxt_s = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RSP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, operand capture and result registers; rst discards any in-flight work.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         rr_ptr_r <= '0;
         id_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         res_r    <= '0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == IDLE) && grant_found_s) begin
            id_r     <= grant_idx_s;
            a_r      <= req_a[grant_idx_s];
            b_r      <= req_b[grant_idx_s];
            rr_ptr_r <= ptr_nxt_s;
         end
         if (state_r == CMP) begin
            res_r.id      <= ID_W_MAX'(id_r);
            res_r.greater <= gt_s;
            res_r.equal   <= eq_s;
            res_r.less    <= lt_s;
         end
      end
   end

   assign rsp_valid   = (state_r == RSP);
   assign busy        = (state_r != IDLE);
   assign rsp_id      = res_r.id[IDX_W-1:0];
   assign rsp_greater = res_r.greater;
   assign rsp_equal   = res_r.equal;
   assign rsp_less    = res_r.less;
   assign unused_id_s = ^res_r.id;

`ifdef CMP_SCHED_STATS_EN
   logic [15:0] stat_count_r;

   // Completed-response counter, wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_count_r <= 16'd0;
      end else if (rsp_valid && rsp_ready) begin
         stat_count_r <= stat_count_r + 16'd1;
      end else begin
         stat_count_r <= stat_count_r;
      end
   end

   assign stat_count = stat_count_r;
`else
   // No statistics counter in this build.
`endif

endmodule
